// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures execute-stage results and memory-stage controls.
// Optional performance counters are enabled by defining EX_MEM_PERF_CNT_EN.
module ex_mem_reg #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned PCW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [PCW-1:0]  branch_target,
    input  logic            zero,
    input  logic [4:0]      rd,
    input  logic [2:0]      funct3,
    input  logic            MemtoReg,
    input  logic            regwrite,
    input  logic            branch,
    input  logic            MemRead,
    input  logic            MemWrite,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [PCW-1:0]  branch_target_out,
    output logic            zero_out,
    output logic [4:0]      rd_out,
    output logic [2:0]      funct3_out,
    output logic            MemtoReg_out,
    output logic            regwrite_out,
    output logic            branch_out,
    output logic            MemRead_out,
    output logic            MemWrite_out,
    output logic            pcsrc
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    logic load;
    assign load = !flush && !stall;

    // Data fields: cleared by reset, held on flush and stall, captured on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_out    <= '0;
            rs2_data_out      <= '0;
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            rd_out            <= '0;
            funct3_out        <= '0;
        end else if (load) begin
            alu_result_out    <= alu_result;
            rs2_data_out      <= rs2_data;
            branch_target_out <= branch_target;
            zero_out          <= zero;
            rd_out            <= rd;
            funct3_out        <= funct3;
        end
    end

    // Valid and controls: bubbles (flush, or load with valid_in=0) zero every control.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_out    <= 1'b0;
            MemtoReg_out <= 1'b0;
            regwrite_out <= 1'b0;
            branch_out   <= 1'b0;
            MemRead_out  <= 1'b0;
            MemWrite_out <= 1'b0;
        end else if (!stall) begin
            valid_out    <= valid_in;
            MemtoReg_out <= valid_in & MemtoReg;
            regwrite_out <= valid_in & regwrite;
            branch_out   <= valid_in & branch;
            MemRead_out  <= valid_in & MemRead;
            MemWrite_out <= valid_in & MemWrite;
        end
    end

    assign pcsrc = branch_out & zero_out & valid_out;

`ifdef EX_MEM_PERF_CNT_EN
    // Saturating event counters; they keep counting through stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the pipeline register.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst, valid_in, stall, flush;
    logic [63:0] alu_result, rs2_data;
    logic [31:0] branch_target;
    logic        zero;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        MemtoReg, regwrite, branch, MemRead, MemWrite;
    logic        valid_out;
    logic [63:0] alu_result_out, rs2_data_out;
    logic [31:0] branch_target_out;
    logic        zero_out;
    logic [4:0]  rd_out;
    logic [2:0]  funct3_out;
    logic        MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out;
    logic        pcsrc;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;
    bit          cmp_en = 1'b0;

    always #5 clk = ~clk;

    ex_mem_reg #(.XLEN(64), .PCW(32)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
        .alu_result(alu_result), .rs2_data(rs2_data), .branch_target(branch_target),
        .zero(zero), .rd(rd), .funct3(funct3),
        .MemtoReg(MemtoReg), .regwrite(regwrite), .branch(branch),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .valid_out(valid_out), .alu_result_out(alu_result_out), .rs2_data_out(rs2_data_out),
        .branch_target_out(branch_target_out), .zero_out(zero_out), .rd_out(rd_out),
        .funct3_out(funct3_out), .MemtoReg_out(MemtoReg_out), .regwrite_out(regwrite_out),
        .branch_out(branch_out), .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
        .pcsrc(pcsrc)
`ifdef EX_MEM_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the stage must hold after each clock edge.
    typedef struct {
        logic        v;
        logic [63:0] alu, rs2;
        logic [31:0] bt;
        logic        z;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        m2r, rw, br, mr, mw;
    } stage_t;

    stage_t      m;
    bit          data_known;
    longint unsigned m_scnt, m_fcnt;

    always @(posedge clk) begin
        if (rst) begin
            m = '{default: '0};
            data_known = 1'b1;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (stall && !flush && m_scnt < 64'hFFFF_FFFF) m_scnt++;
            if (flush && m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
            if (flush) begin
                m.v = 0; m.m2r = 0; m.rw = 0; m.br = 0; m.mr = 0; m.mw = 0;
                data_known = 1'b0;
            end else if (!stall) begin
                m.v   = valid_in;
                m.alu = alu_result; m.rs2 = rs2_data; m.bt = branch_target;
                m.z   = zero; m.rd = rd; m.f3 = funct3;
                m.m2r = valid_in && MemtoReg;
                m.rw  = valid_in && regwrite;
                m.br  = valid_in && branch;
                m.mr  = valid_in && MemRead;
                m.mw  = valid_in && MemWrite;
                data_known = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid_out", valid_out, m.v);
            check("MemtoReg_out", MemtoReg_out, m.m2r);
            check("regwrite_out", regwrite_out, m.rw);
            check("branch_out", branch_out, m.br);
            check("MemRead_out", MemRead_out, m.mr);
            check("MemWrite_out", MemWrite_out, m.mw);
            check("pcsrc", pcsrc, m.br & m.z & m.v);
            if (!valid_out)
                check("no_mem_when_invalid", {MemRead_out, MemWrite_out, regwrite_out}, 0);
            if (data_known) begin
                check("alu_result_out", alu_result_out, m.alu);
                check("rs2_data_out", rs2_data_out, m.rs2);
                check("branch_target_out", branch_target_out, m.bt);
                check("zero_out", zero_out, m.z);
                check("rd_out", rd_out, m.rd);
                check("funct3_out", funct3_out, m.f3);
            end
`ifdef EX_MEM_PERF_CNT_EN
            check("stall_cnt", stall_cnt, m_scnt);
            check("flush_cnt", flush_cnt, m_fcnt);
`endif
        end
    end

    task automatic idle_inputs();
        valid_in = 0; stall = 0; flush = 0;
        alu_result = '0; rs2_data = '0; branch_target = '0; zero = 0; rd = '0; funct3 = '0;
        MemtoReg = 0; regwrite = 0; branch = 0; MemRead = 0; MemWrite = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        idle_inputs();
        alu_result = 64'hDEAD; rd = 5'd7; regwrite = 1; valid_in = 1;
        step(); step();
        cmp_en = 1'b1;
        check("reset_valid", valid_out, 0);
        check("reset_alu", alu_result_out, 0);
        check("reset_rd", rd_out, 0);
        check("reset_regwrite", regwrite_out, 0);
        check("reset_pcsrc", pcsrc, 0);

        // Simple load
        rst = 0; idle_inputs();
        valid_in = 1; alu_result = 64'h10; rd = 5'd5; regwrite = 1;
        step();
        check("load_alu", alu_result_out, 64'h10);
        check("load_rd", rd_out, 5);
        check("load_regwrite", regwrite_out, 1);
        check("load_valid", valid_out, 1);

        // Stall holds A while inputs move to B
        stall = 1; alu_result = 64'hBB; rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_alu", alu_result_out, 64'h10);
            check("stall_hold_rd", rd_out, 5);
        end
        stall = 0;
        step();
        check("after_stall_alu", alu_result_out, 64'hBB);
        check("after_stall_rd", rd_out, 9);

        // Flush together with stall kills a store
        idle_inputs(); valid_in = 1; MemWrite = 1;
        step();
        check("store_loaded", MemWrite_out, 1);
        flush = 1; stall = 1;
        step();
        check("flush_valid", valid_out, 0);
        check("flush_memwrite", MemWrite_out, 0);
        check("flush_pcsrc", pcsrc, 0);

        // Branch taken / not taken
        idle_inputs(); valid_in = 1; branch = 1; zero = 1; branch_target = 32'h100;
        step();
        check("branch_pcsrc", pcsrc, 1);
        check("branch_target", branch_target_out, 32'h100);
        zero = 0;
        step();
        check("branch_nz_pcsrc", pcsrc, 0);

        // Bubble
        idle_inputs(); regwrite = 1; MemRead = 1;
        step();
        check("bubble_valid", valid_out, 0);
        check("bubble_regwrite", regwrite_out, 0);
        check("bubble_memread", MemRead_out, 0);

        // Reset during a stall with loaded state
        idle_inputs(); valid_in = 1; alu_result = 64'h55; rd = 5'd3; branch = 1; zero = 1;
        step();
        stall = 1; rst = 1;
        step();
        check("rst_mid_valid", valid_out, 0);
        check("rst_mid_alu", alu_result_out, 0);
        check("rst_mid_rd", rd_out, 0);
        check("rst_mid_pcsrc", pcsrc, 0);
`ifdef EX_MEM_PERF_CNT_EN
        check("rst_mid_stall_cnt", stall_cnt, 0);
        check("rst_mid_flush_cnt", flush_cnt, 0);
`endif
        rst = 0; stall = 0; valid_in = 1; alu_result = 64'h77;
        step();
        check("post_rst_load", alu_result_out, 64'h77);

        // Randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(99) < 3);
            flush         = ($urandom_range(99) < 10);
            stall         = ($urandom_range(99) < 25);
            valid_in      = ($urandom_range(99) < 75);
            alu_result    = {$urandom, $urandom};
            rs2_data      = {$urandom, $urandom};
            branch_target = $urandom;
            zero          = $urandom_range(1);
            rd            = 5'($urandom);
            funct3        = 3'($urandom);
            MemtoReg      = $urandom_range(1);
            regwrite      = $urandom_range(1);
            branch        = $urandom_range(1);
            MemRead       = $urandom_range(1);
            MemWrite      = $urandom_range(1);
            step();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have parameter XLEN, default 64, data-path width.
REQ-002 SHALL have parameter PCW, default 32, program-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 SHALL have port valid_in  input  1  EX stage holds a real instruction.
REQ-006 SHALL have port stall  input  1  hold all registered contents this cycle.
REQ-007 SHALL have port flush  input  1  replace captured contents with a bubble.
REQ-008 SHALL have ports alu_result / rs2_data  input  XLEN  ALU output / store data.
REQ-009 SHALL have ports branch_target  input  PCW, zero  input  1, rd  input  5, funct3  input  3.
REQ-010 SHALL have control inputs MemtoReg, regwrite, branch, MemRead, MemWrite, each 1 bit.
REQ-011 SHALL have registered outputs valid_out, alu_result_out, rs2_data_out, branch_target_out, zero_out, rd_out, funct3_out, MemtoReg_out, regwrite_out, branch_out, MemRead_out, MemWrite_out, each the width of its input.
REQ-012 SHALL have output pcsrc  1  combinational: branch_out & zero_out & valid_out.

Function
REQ-013 SHALL select the update per cycle with priority rst > flush > stall > load.
REQ-014 On load (no rst/flush/stall), SHALL capture every input into its *_out register; latency exactly 1 cycle.
REQ-015 When valid_in=0 on load, SHALL capture data fields but force valid_out and all five control outputs to 0.
REQ-016 On stall, SHALL hold every output register unchanged, including valid_out.
REQ-017 On flush, SHALL clear valid_out and all control outputs to 0; data fields are don't-care (implementation holds them).
REQ-018 Simultaneous flush and stall SHALL behave as flush.
REQ-019 SHALL never assert MemRead_out, MemWrite_out or regwrite_out while valid_out=0.
REQ-020 MemRead_out and MemWrite_out both 1 is illegal input; SHALL pass through unmodified (no arbitration).
REQ-021 pcsrc SHALL follow register outputs in the same cycle with no added latency.

Reset
REQ-022 On rst, SHALL set every output register to 0 (valid_out=0, all data, rd, funct3, controls zero); pcsrc consequently 0.
REQ-023 rst asserted mid-stall or mid-flush SHALL override both; first cycle after rst deasserts performs a normal load.

Configuration
REQ-024 Macro EX_MEM_PERF_CNT_EN SHALL, when defined, add outputs stall_cnt and flush_cnt (32 bits each).
REQ-025 With EX_MEM_PERF_CNT_EN: stall_cnt increments on cycles with stall=1 and flush=0; flush_cnt increments on cycles with flush=1; both saturate at 32'hFFFFFFFF, clear on rst, and are unaffected by stall.
REQ-026 Without EX_MEM_PERF_CNT_EN, SHALL omit the counter ports and logic entirely; all other behaviour is identical.

Verification
REQ-027 Load: valid_in=1, alu_result=64'h10, rd=5, regwrite=1 -> next cycle alu_result_out=64'h10, rd_out=5, regwrite_out=1, valid_out=1.
REQ-028 Stall hold: load value A, then stall=1 for 3 cycles while inputs change to B -> outputs remain A all 3 cycles; B captured on the first non-stall cycle.
REQ-029 Flush with stall: valid register holding MemWrite=1, assert flush=1 and stall=1 together -> next cycle valid_out=0, MemWrite_out=0, pcsrc=0.
REQ-030 Branch: branch=1, zero=1, valid_in=1, branch_target=32'h100 -> next cycle pcsrc=1, branch_target_out=32'h100; same with zero=0 -> pcsrc=0.
REQ-031 Bubble: valid_in=0 with regwrite=1, MemRead=1 -> next cycle valid_out=0, regwrite_out=0, MemRead_out=0.
REQ-032 Reset mid-op: rst=1 during stall with loaded state -> next cycle all outputs 0; with EX_MEM_PERF_CNT_EN, stall_cnt=0 and a preloaded saturated flush_cnt returns to 0.
